// File: rtl/motor_uart_pkg.sv
// -----------------------------------------------------------------------------
// motor_uart_pkg
// Definitions shared by the status frame transmitter and the host-to-board
// command parser: the frame sync byte, the frame FSM state encoding and the
// baud divisor helper.
// No ports (package).
// -----------------------------------------------------------------------------
package motor_uart_pkg;

    // First byte of every frame ("S").
    localparam logic [7:0] SYNC_BYTE = 8'h53;

    // Frame FSM states: one state per frame byte plus idle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_NUM  = 2'd2,
        ST_POS  = 2'd3
    } frame_state_e;

    // Clocks per serial bit, rounded to nearest: 10 MHz / 230400 -> 43.
    function automatic int unsigned baud_divisor(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// -----------------------------------------------------------------------------
// uart_tx_core
// Byte serialiser: start bit 0, 8 data bits LSB first, one stop bit 1.
// Every bit lasts exactly Divisor clocks.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   load_i        load data_i; taken when idle or in the last stop-bit clock
//   data_i        byte to send
//   txd_o         serial line, idle high (registered)
//   busy_o        a byte is on the line
//   done_o        high during the final clock of the stop bit
// Loading in the same clock as done_o puts the next start bit straight after
// the stop bit, so callers can chain bytes without an idle gap.
// -----------------------------------------------------------------------------
module uart_tx_core #(
    parameter int unsigned Divisor = 43
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       txd_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int unsigned CntW = (Divisor > 1) ? $clog2(Divisor) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(Divisor - 1);

    logic [CntW-1:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;   // 0 = start, 1..8 = data, 9 = stop
    logic [8:0]      shift_q, shift_d;       // remaining data bits + stop bit
    logic            active_q, active_d;
    logic            txd_q, txd_d;
    logic            bit_end;

    assign bit_end = active_q && (baud_cnt_q == CntLast);
    assign done_o  = bit_end && (bit_cnt_q == 4'd9);
    assign busy_o  = active_q;
    assign txd_o   = txd_q;

    always_comb begin
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        active_d   = active_q;
        txd_d      = txd_q;
        if (load_i && (!active_q || done_o)) begin
            txd_d      = 1'b0;
            shift_d    = {1'b1, data_i};
            bit_cnt_d  = 4'd0;
            baud_cnt_d = '0;
            active_d   = 1'b1;
        end else if (bit_end) begin
            baud_cnt_d = '0;
            if (bit_cnt_q == 4'd9) begin
                active_d = 1'b0;
                txd_d    = 1'b1;
            end else begin
                txd_d     = shift_q[0];
                shift_d   = {1'b1, shift_q[8:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (active_q) begin
            baud_cnt_d = baud_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            baud_cnt_q <= '0;
            bit_cnt_q  <= 4'd0;
            shift_q    <= '1;
            active_q   <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            active_q   <= active_d;
            txd_q      <= txd_d;
        end
    end

endmodule

// File: rtl/status_frame_tx.sv
// -----------------------------------------------------------------------------
// status_frame_tx
// Queues motor status reports and sends each as a 3-byte UART frame:
// SYNC_BYTE, {4'h0, num}, pos. Frames and bytes follow each other with no gap.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   rep_valid     report request
//   rep_ready     report can be accepted (FIFO not full, not in reset)
//   rep_num       motor index (sent unchanged, including 12..15)
//   rep_pos       position byte
//   TxD           UART output, idle high
//   busy          FIFO non-empty or frame in progress
//   dbg_state_o   current frame FSM state (frame_state_e encoding)
// Handshake: a report is taken on every rising edge where rep_valid and
// rep_ready are both 1; rep_ready does not depend on rep_valid, and a full
// FIFO refuses even if an entry is popped in the same clock.
// -----------------------------------------------------------------------------
module status_frame_tx
    import motor_uart_pkg::*;
#(
    parameter int unsigned ClkFrequency = 10000000,
    parameter int unsigned Baud         = 230400,
    parameter int unsigned FifoDepth    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rep_valid,
    output logic       rep_ready,
    input  logic [3:0] rep_num,
    input  logic [7:0] rep_pos,
    output logic       TxD,
    output logic       busy,
    output logic [1:0] dbg_state_o
);

    localparam int unsigned Divisor = baud_divisor(ClkFrequency, Baud);
    localparam int unsigned PtrW    = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntW    = $clog2(FifoDepth + 1);

    // ---------------- report FIFO ----------------
    logic [11:0]     fifo_mem [FifoDepth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push, pop, fifo_empty;
    logic [11:0]     fifo_head;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FifoDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign rep_ready  = !rst && (count_q < CntW'(FifoDepth));
    assign push       = rep_valid && rep_ready;
    assign fifo_empty = (count_q == '0);
    assign fifo_head  = fifo_mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {rep_num, rep_pos};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ---------------- frame FSM ----------------
    frame_state_e state_q, state_d;
    logic [11:0]  frame_q, frame_d;   // entry being sent, isolated from FIFO writes
    logic         core_load, core_busy, core_done;
    logic [7:0]   core_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: if (core_done) state_d = ST_NUM;
            ST_NUM:  if (core_done) state_d = ST_POS;
            ST_POS: begin
                if (core_done) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_SYNC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        frame_d = pop ? fifo_head : frame_q;
    end

    // Each state loads the byte of the following state on completion. SYNC
    // entered from IDLE finds the core idle and loads the sync byte itself,
    // which gives the two-clock accept-to-start-bit latency.
    always_comb begin
        core_load = 1'b0;
        core_data = SYNC_BYTE;
        case (state_q)
            ST_SYNC: begin
                if (!core_busy) begin
                    core_load = 1'b1;
                end else if (core_done) begin
                    core_load = 1'b1;
                    core_data = {4'h0, frame_q[11:8]};
                end
            end
            ST_NUM: begin
                core_load = core_done;
                core_data = frame_q[7:0];
            end
            ST_POS: core_load = core_done && !fifo_empty;
            default: core_load = 1'b0;
        endcase
        busy        = (state_q != ST_IDLE) || !fifo_empty;
        dbg_state_o = state_q;
    end

    uart_tx_core #(
        .Divisor (Divisor)
    ) u_tx (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (core_load),
        .data_i (core_data),
        .txd_o  (TxD),
        .busy_o (core_busy),
        .done_o (core_done)
    );

endmodule
